// File: rtl/uart_prog_pkg.sv
// Shared definitions for the UART program loader: oversampling factor,
// RX and loader state encodings, and the baud divider helper.
package uart_prog_pkg;

   localparam int OVERSAMPLE = 16;

   typedef enum logic [1:0] {
      R_IDLE  = 2'd0,
      R_START = 2'd1,
      R_DATA  = 2'd2,
      R_STOP  = 2'd3
   } rx_state_e;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LEN0 = 3'd1,
      S_LEN1 = 3'd2,
      S_DATA = 3'd3,
      S_DONE = 3'd4
   } ld_state_e;

   // Clocks per oversampling tick; never below one so the divider stays legal.
   function automatic int baud_div(input int clk_hz, input int baud);
      int div;
      div = clk_hz / (baud * OVERSAMPLE);
      if (div < 1) begin
         div = 1;
      end else begin
         div = div;
      end
      return div;
   endfunction

endpackage

// File: rtl/uart_prog_loader_if.sv
// Programming-port bus between the loader (master) and the program ROM port A (slave).
interface uart_prog_loader_if #(
   parameter int ADDR_W = 14
);
   logic              upg_rst;   // 1 = fetch owns ROM, 0 = loading
   logic              upg_wen;   // one-cycle write strobe
   logic [ADDR_W-1:0] upg_adr;   // word address
   logic [31:0]       upg_dat;   // write data
   logic              upg_done;  // sticky session-complete flag

   modport master (
      output upg_rst,
      output upg_wen,
      output upg_adr,
      output upg_dat,
      output upg_done
   );

   modport slave (
      input upg_rst,
      input upg_wen,
      input upg_adr,
      input upg_dat,
      input upg_done
   );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-FF input synchronizer, free-running 16x tick divider
// and a tick-qualified RX FSM producing one-clock byte / framing-error pulses.
module uart_rx_core
   import uart_prog_pkg::*;
#(
   parameter int CLK_HZ = 100_000_000,
   parameter int BAUD   = 128_000
) (
   input  logic       clk,
   input  logic       rst,        // asynchronous, active-low
   input  logic       rx_i,
   output logic [7:0] byte_o,
   output logic       byte_vld_o,
   output logic       ferr_o
);

   localparam int DIV   = baud_div(CLK_HZ, BAUD);
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [1:0]       sync_q;
   logic             prev_q;
   logic [DIV_W-1:0] div_q;
   logic             tick_s;
   logic             rx_s;
   logic             fall_s;

   rx_state_e        state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             vld_q, vld_d;
   logic             ferr_q, ferr_d;

   assign rx_s   = sync_q[1];
   assign fall_s = prev_q & ~sync_q[1];
   assign tick_s = (div_q == DIV_W'(DIV - 1));

   // Bring the asynchronous line into the clk domain and keep the previous level for edge detect.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= 2'b11;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[0], rx_i};
         prev_q <= sync_q[1];
      end
   end

   // Free-running oversampling divider; tick fires once every DIV clocks.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q <= '0;
      end else if (tick_s) begin
         div_q <= '0;
      end else begin
         div_q <= div_q + DIV_W'(1);
      end
   end

   // RX FSM state and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= R_IDLE;
         cnt_q   <= 4'd0;
         bit_q   <= 3'd0;
         shift_q <= 8'd0;
         vld_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         vld_q   <= vld_d;
         ferr_q  <= ferr_d;
      end
   end

   // RX next-state: mid-bit sampling, start-bit glitch rejection, stop-bit check.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      vld_d   = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         R_IDLE: begin
            cnt_d = 4'd0;
            bit_d = 3'd0;
            if (fall_s) begin
               state_d = R_START;
            end else begin
               state_d = R_IDLE;
            end
         end
         R_START: begin
            if (tick_s) begin
               if (cnt_q == 4'd7) begin
                  cnt_d = 4'd0;
                  if (rx_s == 1'b0) begin
                     state_d = R_DATA;
                  end else begin
                     state_d = R_IDLE;   // line back high: glitch, not a start bit
                  end
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         R_DATA: begin
            if (tick_s) begin
               if (cnt_q == 4'd15) begin
                  cnt_d   = 4'd0;
                  shift_d = {rx_s, shift_q[7:1]};   // LSB arrives first
                  bit_d   = bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
                     state_d = R_STOP;
                  end else begin
                     state_d = R_DATA;
                  end
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         R_STOP: begin
            if (tick_s) begin
               if (cnt_q == 4'd15) begin
                  cnt_d   = 4'd0;
                  state_d = R_IDLE;
                  if (rx_s) begin
                     vld_d = 1'b1;
                  end else begin
                     ferr_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         default: begin
            state_d = R_IDLE;
         end
      endcase
   end

   assign byte_o     = shift_q;
   assign byte_vld_o = vld_q;
   assign ferr_o     = ferr_q;

endmodule

// File: rtl/uart_prog_loader.sv
// Receives a length-prefixed program image over UART and turns it into
// 32-bit word writes on the programming bus; releases fetch when complete.
module uart_prog_loader
   import uart_prog_pkg::*;
#(
   parameter int CLK_HZ    = 100_000_000,
   parameter int BAUD      = 128_000,
   parameter int ADDR_W    = 14,
   parameter int MAX_WORDS = 16384
) (
   input  logic               clk,
   input  logic               rst,          // asynchronous, active-low
   input  logic               start_i,
   input  logic               rx_i,
   output logic               frame_err_o,
   uart_prog_loader_if.master upg
);

   localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

   logic [7:0]        rx_byte_s;
   logic              rx_vld_s;
   logic              rx_ferr_s;

   ld_state_e         state_q, state_d;
   logic [16:0]       word_idx_q, word_idx_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [7:0]        len_lo_q, len_lo_d;
   logic [16:0]       eff_q, eff_d;
   logic [23:0]       buf_q, buf_d;
   logic              upg_rst_q, upg_rst_d;
   logic              wen_q, wen_d;
   logic [ADDR_W-1:0] adr_q, adr_d;
   logic [31:0]       dat_q, dat_d;
   logic              done_q, done_d;
   logic              ferr_q, ferr_d;

   logic [15:0]       len_s;
   logic [16:0]       eff_s;
   logic [16:0]       word_nxt_s;
   logic              abort_s;

   uart_rx_core #(
      .CLK_HZ (CLK_HZ),
      .BAUD   (BAUD)
   ) u_rx (
      .clk        (clk),
      .rst        (rst),
      .rx_i       (rx_i),
      .byte_o     (rx_byte_s),
      .byte_vld_o (rx_vld_s),
      .ferr_o     (rx_ferr_s)
   );

   // Word count arrives high byte second; oversize images are clamped.
   assign len_s      = {rx_byte_s, len_lo_q};
   assign eff_s      = ({1'b0, len_s} > MAX_W) ? MAX_W : {1'b0, len_s};
   assign word_nxt_s = word_idx_q + 17'd1;
   assign abort_s    = rx_ferr_s && (state_q inside {S_LEN0, S_LEN1, S_DATA});

   // Loader state, counters, word buffer and registered bus outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         word_idx_q <= 17'd0;
         byte_idx_q <= 2'd0;
         len_lo_q   <= 8'd0;
         eff_q      <= 17'd0;
         buf_q      <= 24'd0;
         upg_rst_q  <= 1'b1;
         wen_q      <= 1'b0;
         adr_q      <= '0;
         dat_q      <= 32'd0;
         done_q     <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_idx_q <= word_idx_d;
         byte_idx_q <= byte_idx_d;
         len_lo_q   <= len_lo_d;
         eff_q      <= eff_d;
         buf_q      <= buf_d;
         upg_rst_q  <= upg_rst_d;
         wen_q      <= wen_d;
         adr_q      <= adr_d;
         dat_q      <= dat_d;
         done_q     <= done_d;
         ferr_q     <= ferr_d;
      end
   end

   // Loader next-state: start_i restarts from any state and beats a coincident byte.
   always_comb begin
      state_d    = state_q;
      word_idx_d = word_idx_q;
      byte_idx_d = byte_idx_q;
      len_lo_d   = len_lo_q;
      eff_d      = eff_q;
      buf_d      = buf_q;
      upg_rst_d  = upg_rst_q;
      wen_d      = 1'b0;
      adr_d      = adr_q;
      dat_d      = dat_q;
      done_d     = done_q;
      ferr_d     = ferr_q;
      if (start_i) begin
         state_d    = S_LEN0;
         word_idx_d = 17'd0;
         byte_idx_d = 2'd0;
         upg_rst_d  = 1'b0;
         done_d     = 1'b0;
         ferr_d     = 1'b0;
      end else if (abort_s) begin
         // Bad stop bit: give ROM back to fetch, leave the partial image in place.
         state_d   = S_IDLE;
         upg_rst_d = 1'b1;
         done_d    = 1'b0;
         ferr_d    = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               upg_rst_d = 1'b1;
            end
            S_LEN0: begin
               if (rx_vld_s) begin
                  len_lo_d = rx_byte_s;
                  state_d  = S_LEN1;
               end else begin
                  state_d = S_LEN0;
               end
            end
            S_LEN1: begin
               if (rx_vld_s) begin
                  eff_d = eff_s;
                  if (eff_s == 17'd0) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_DATA;
                  end
               end else begin
                  state_d = S_LEN1;
               end
            end
            S_DATA: begin
               if (rx_vld_s) begin
                  case (byte_idx_q)
                     2'd0: buf_d[7:0]   = rx_byte_s;
                     2'd1: buf_d[15:8]  = rx_byte_s;
                     2'd2: buf_d[23:16] = rx_byte_s;
                     default: begin
                        wen_d      = 1'b1;
                        adr_d      = word_idx_q[ADDR_W-1:0];
                        dat_d      = {rx_byte_s, buf_q};
                        word_idx_d = word_nxt_s;
                        if (word_nxt_s == eff_q) begin
                           state_d = S_DONE;
                        end else begin
                           state_d = S_DATA;
                        end
                     end
                  endcase
                  byte_idx_d = byte_idx_q + 2'd1;   // 3 wraps to 0 for the next word
               end else begin
                  state_d = S_DATA;
               end
            end
            S_DONE: begin
               done_d    = 1'b1;
               upg_rst_d = 1'b1;
               state_d   = S_IDLE;
            end
            default: begin
               state_d   = S_IDLE;
               upg_rst_d = 1'b1;
            end
         endcase
      end
   end

   assign upg.upg_rst  = upg_rst_q;
   assign upg.upg_wen  = wen_q;
   assign upg.upg_adr  = adr_q;
   assign upg.upg_dat  = dat_q;
   assign upg.upg_done = done_q;
   assign frame_err_o  = ferr_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: serialises images onto rx_i and compares the
// observed ROM writes with an image-level model of the load protocol.
module tb_uart_prog_loader;

   localparam int CLK_HZ    = 16_000_000;
   localparam int BAUD      = 250_000;
   localparam int ADDR_W    = 4;
   localparam int MAX_WORDS = 3;
   localparam int BIT_T     = 640;   // 4 clks/tick * 16 ticks * 10 time units/clk

   logic clk = 1'b0;
   logic rst_n;
   logic start;
   logic rx;
   logic frame_err;

   int n_checks = 0;
   int n_errors = 0;
   int wen_wide = 0;
   bit wen_prev = 1'b0;

   logic [7:0]        tx_q[$];
   logic [ADDR_W-1:0] exp_adr[$];
   logic [31:0]       exp_dat[$];
   logic [ADDR_W-1:0] obs_adr[$];
   logic [31:0]       obs_dat[$];

   uart_prog_loader_if #(.ADDR_W(ADDR_W)) upg_bus ();

   uart_prog_loader #(
      .CLK_HZ    (CLK_HZ),
      .BAUD      (BAUD),
      .ADDR_W    (ADDR_W),
      .MAX_WORDS (MAX_WORDS)
   ) dut (
      .clk         (clk),
      .rst         (rst_n),
      .start_i     (start),
      .rx_i        (rx),
      .frame_err_o (frame_err),
      .upg         (upg_bus)
   );

   always #5 clk = ~clk;

   // Record every write and flag strobes wider than one clock.
   always @(negedge clk) begin
      if (upg_bus.upg_wen === 1'b1) begin
         obs_adr.push_back(upg_bus.upg_adr);
         obs_dat.push_back(upg_bus.upg_dat);
         if (wen_prev) wen_wide++;
      end
      wen_prev = (upg_bus.upg_wen === 1'b1);
   end

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Image-level model: count, clamp, little-endian words, only complete words written.
   function automatic bit model_session();
      int n;
      int eff;
      exp_adr.delete();
      exp_dat.delete();
      if (tx_q.size() < 2) return 1'b0;
      n   = int'(tx_q[0]) + 256 * int'(tx_q[1]);
      eff = (n > MAX_WORDS) ? MAX_WORDS : n;
      for (int w = 0; w < eff; w++) begin
         if (2 + 4*w + 3 < tx_q.size()) begin
            exp_adr.push_back(ADDR_W'(w));
            exp_dat.push_back({tx_q[2+4*w+3], tx_q[2+4*w+2], tx_q[2+4*w+1], tx_q[2+4*w]});
         end
      end
      return (tx_q.size() >= 2 + 4*eff);
   endfunction

   task automatic send_byte(input logic [7:0] b, input logic stop_b, input int bit_t);
      rx = 1'b0;
      #(bit_t);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         #(bit_t);
      end
      rx = stop_b;
      #(bit_t);
      rx = 1'b1;
      #(bit_t);
   endtask

   task automatic pulse_start();
      obs_adr.delete();
      obs_dat.delete();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_session(input string tag, input int bit_t, input bit glitch);
      bit exp_done;
      pulse_start();
      chk_eq({tag, "_rst_active"}, 64'(upg_bus.upg_rst), 64'(0));
      chk_eq({tag, "_done_clr"}, 64'(upg_bus.upg_done), 64'(0));
      chk_eq({tag, "_ferr_clr"}, 64'(frame_err), 64'(0));
      if (glitch) begin
         rx = 1'b0;
         #(bit_t * 3 / 16);
         rx = 1'b1;
         #(bit_t * 2);
      end
      foreach (tx_q[i]) send_byte(tx_q[i], 1'b1, bit_t);
      exp_done = model_session();
      for (int i = 0; i < 500 && exp_done && upg_bus.upg_done !== 1'b1; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk_eq({tag, "_done"}, 64'(upg_bus.upg_done), 64'(exp_done));
      chk_eq({tag, "_upg_rst"}, 64'(upg_bus.upg_rst), 64'(exp_done));
      chk_eq({tag, "_nwrites"}, 64'(obs_adr.size()), 64'(exp_adr.size()));
      for (int i = 0; i < exp_adr.size() && i < obs_adr.size(); i++) begin
         chk_eq($sformatf("%s_adr%0d", tag, i), 64'(obs_adr[i]), 64'(exp_adr[i]));
         chk_eq($sformatf("%s_dat%0d", tag, i), 64'(obs_dat[i]), 64'(exp_dat[i]));
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      rx    = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk_eq("reset_upg_rst", 64'(upg_bus.upg_rst), 64'(1));
      chk_eq("reset_wen", 64'(upg_bus.upg_wen), 64'(0));
      chk_eq("reset_done", 64'(upg_bus.upg_done), 64'(0));
      chk_eq("reset_ferr", 64'(frame_err), 64'(0));
      chk_eq("reset_adr", 64'(upg_bus.upg_adr), 64'(0));
      chk_eq("reset_dat", 64'(upg_bus.upg_dat), 64'(0));

      // Two-word image.
      tx_q = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      do_session("two_words", BIT_T, 1'b0);
      chk_eq("two_words_hold_adr", 64'(upg_bus.upg_adr), 64'(1));
      chk_eq("two_words_hold_dat", 64'(upg_bus.upg_dat), 64'(32'hDEADBEEF));

      // Zero-length image completes without writes.
      tx_q = '{8'h00, 8'h00};
      do_session("empty", BIT_T, 1'b0);

      // Framing error inside a session aborts it.
      pulse_start();
      send_byte(8'h01, 1'b1, BIT_T);
      send_byte(8'h00, 1'b1, BIT_T);
      send_byte(8'h11, 1'b0, BIT_T);
      repeat (4) @(negedge clk);
      chk_eq("ferr_flag", 64'(frame_err), 64'(1));
      chk_eq("ferr_upg_rst", 64'(upg_bus.upg_rst), 64'(1));
      chk_eq("ferr_done", 64'(upg_bus.upg_done), 64'(0));
      chk_eq("ferr_nwrites", 64'(obs_adr.size()), 64'(0));

      // Restart in mid-session: only the second session's word counts after restart.
      tx_q = '{8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
      do_session("partial", BIT_T, 1'b0);
      tx_q = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      do_session("restart", BIT_T, 1'b0);
      chk_eq("restart_hold_dat", 64'(upg_bus.upg_dat), 64'(32'hDDCCBBAA));

      // Oversize image: clamped, surplus bytes land in idle.
      tx_q = '{8'h04, 8'h00};
      repeat (16) tx_q.push_back(8'($urandom));
      do_session("clamp", BIT_T, 1'b0);
      chk_eq("clamp_hold_adr", 64'(upg_bus.upg_adr), 64'(MAX_WORDS - 1));

      // Short low glitch before the length must not become a byte.
      tx_q = '{8'h01, 8'h00};
      repeat (4) tx_q.push_back(8'($urandom));
      do_session("glitch", BIT_T, 1'b1);

      // Baud rate offsets of about +/-2%.
      tx_q = '{8'h01, 8'h00};
      repeat (4) tx_q.push_back(8'($urandom));
      do_session("baud_fast", BIT_T * 98 / 100, 1'b0);
      tx_q = '{8'h01, 8'h00};
      repeat (4) tx_q.push_back(8'($urandom));
      do_session("baud_slow", BIT_T * 102 / 100, 1'b0);

      // Random images.
      for (int s = 0; s < 2; s++) begin
         int n;
         n = $urandom_range(0, 2);
         tx_q = '{8'(n), 8'h00};
         repeat (4 * n) tx_q.push_back(8'($urandom));
         do_session($sformatf("rand%0d", s), BIT_T, 1'b0);
      end

      chk_eq("wen_one_clk", 64'(wen_wide), 64'(0));
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
